// File: rtl/des_pkg.sv
// Shared types and sizes for the DES byte/block staging logic.
package des_pkg;

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

  localparam int BLOCK_BYTES = 8;
  localparam int BLOCK_W     = 64;
  localparam int CNT_W       = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/des_block_buffer_shreg.sv
// 64-bit register with parallel load and byte-wide left shift; the new
// byte enters at the bottom so the first byte shifted in ends up on top.
module byte_shreg
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic [7:0]         shift_in,
  output logic [BLOCK_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[BLOCK_W-9:0], shift_in};
    end
  end

endmodule

// File: rtl/des_block_buffer.sv
// Packs eight I2C bytes into a block for the des core, then returns the
// core's result byte by byte; an optional watchdog aborts a silent core.
module des_block_buffer
  import des_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  input  logic               mode_in,
  output logic [BLOCK_W-1:0] des_data_in,
  output logic               des_ready,
  output logic               des_rw_mode,
  input  logic [BLOCK_W-1:0] des_data_out,
  input  logic               des_next_data,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ack,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [WD_W-1:0]    wd_cnt;
  logic [BLOCK_W-1:0] result;
  logic               fill_shift;
  logic               drain_load;
  logic               drain_shift;
  logic               last_byte;
  logic               wd_expire;

  // The byte counter is shared: it counts received bytes in FILL and acks in DRAIN.
  assign last_byte = (count == CNT_W'(BLOCK_BYTES - 1));
  assign wd_expire = (TIMEOUT > 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    fill_shift  = 1'b0;
    drain_load  = 1'b0;
    drain_shift = 1'b0;
    case (state)
      FILL: begin
        if (rx_valid) begin
          fill_shift = 1'b1;
          if (last_byte) state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the expiry edge still wins over the abort.
        if (des_next_data) begin
          drain_load = 1'b1;
          state_nxt  = DRAIN;
        end else if (wd_expire) begin
          state_nxt = FILL;
        end
      end
      DRAIN: begin
        if (tx_ack) begin
          drain_shift = 1'b1;
          if (last_byte) state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (fill_shift || drain_shift) begin
      count <= count + 1'b1;
    end
  end

  // Held at zero outside WAIT so each wait starts from a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      des_rw_mode <= 1'b0;
    end else if (fill_shift && (count == '0)) begin
      des_rw_mode <= mode_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (rx_valid && (state != FILL)) overrun <= 1'b1;
      if ((state == WAIT) && !des_next_data && wd_expire) timeout_err <= 1'b1;
    end
  end

  byte_shreg u_fill (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .shift     (fill_shift),
    .load_data ('0),
    .shift_in  (rx_byte),
    .data      (des_data_in)
  );

  byte_shreg u_drain (
    .clk       (clk),
    .rst       (rst),
    .load      (drain_load),
    .shift     (drain_shift),
    .load_data (des_data_out),
    .shift_in  (8'h00),
    .data      (result)
  );

  assign des_ready = (state == WAIT);
  assign tx_valid  = (state == DRAIN);
  assign tx_byte   = result[BLOCK_W-1 -: 8];
  assign busy      = (state != FILL) || (count != '0);

endmodule

// File: tb/tb_des_block_buffer.sv
// Self-checking bench for des_block_buffer with a behavioural des stub.
module tb_des_block_buffer;

  localparam int TIMEOUT = 16;
  localparam logic [63:0] STUB_KEY = 64'ha5c3_0f96_5a3c_f069;

  typedef logic [7:0] block_bytes_t [8];

  logic        tb_clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        mode_in;
  logic [63:0] des_data_in;
  logic        des_ready;
  logic        des_rw_mode;
  logic [63:0] des_data_out;
  logic        des_next_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ack;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  des_block_buffer #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .mode_in       (mode_in),
    .des_data_in   (des_data_in),
    .des_ready     (des_ready),
    .des_rw_mode   (des_rw_mode),
    .des_data_out  (des_data_out),
    .des_next_data (des_next_data),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ack        (tx_ack),
    .busy          (busy),
    .overrun       (overrun),
    .timeout_err   (timeout_err)
  );

  always #5 tb_clk = ~tb_clk;

  // Invertible stand-in for the cipher: rotate-then-xor, undone by xor-then-rotate.
  function automatic logic [63:0] stub_des(input logic [63:0] x, input logic mode);
    logic [63:0] y;
    if (!mode) return {x[55:0], x[63:56]} ^ STUB_KEY;
    y = x ^ STUB_KEY;
    return {y[7:0], y[63:8]};
  endfunction

  function automatic logic [63:0] pack_bytes(input block_bytes_t b);
    logic [63:0] acc = '0;
    for (int i = 0; i < 8; i++) acc = acc + (64'(b[i]) << (8 * (7 - i)));
    return acc;
  endfunction

  function automatic block_bytes_t to_bytes(input logic [63:0] v);
    block_bytes_t b;
    for (int i = 0; i < 8; i++) b[i] = 8'(v >> (8 * (7 - i)));
    return b;
  endfunction

  function automatic block_bytes_t rand_bytes();
    block_bytes_t b;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send_block(input block_bytes_t b, input logic mode,
                            input int unsigned n, input int unsigned max_gap);
    for (int i = 0; i < int'(n); i++) begin
      rx_byte  = b[i];
      rx_valid = 1'b1;
      mode_in  = (i == 0) ? mode : 1'($urandom_range(0, 1));
      step();
      rx_valid = 1'b0;
      mode_in  = 1'b0;
      if (i == 6) check_bit("ready_before_8th", des_ready, 1'b0);
      if (i < 7) repeat ($urandom_range(0, max_gap)) step();
    end
    if (n == 8) begin
      check_bit("ready_after_8th", des_ready, 1'b1);
      check_word("block", des_data_in, pack_bytes(b));
      check_bit("rw_mode", des_rw_mode, mode);
      check_bit("busy_wait", busy, 1'b1);
    end
  endtask

  task automatic respond(input logic [63:0] res, input int unsigned latency);
    repeat (latency) step();
    check_bit("ready_held", des_ready, 1'b1);
    des_data_out  = res;
    des_next_data = 1'b1;
    step();
    des_next_data = 1'b0;
    des_data_out  = {$urandom, $urandom};
    check_bit("ready_dropped", des_ready, 1'b0);
    check_bit("tx_valid_rise", tx_valid, 1'b1);
  endtask

  task automatic drain(input logic [63:0] res, input int unsigned max_gap,
                       output logic [63:0] got);
    got = '0;
    for (int i = 0; i < 8; i++) begin
      check_bit("tx_valid", tx_valid, 1'b1);
      check_word("tx_byte", 64'(tx_byte), 64'(to_bytes(res)[i]));
      got    = (got << 8) | 64'(tx_byte);
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
      repeat ($urandom_range(0, max_gap)) step();
    end
    check_bit("tx_valid_end", tx_valid, 1'b0);
    check_bit("busy_idle", busy, 1'b0);
  endtask

  task automatic check_reset_state();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_ready", des_ready, 1'b0);
    check_word("rst_data_in", des_data_in, 64'h0);
    check_bit("rst_rw_mode", des_rw_mode, 1'b0);
    check_bit("rst_tx_valid", tx_valid, 1'b0);
    check_word("rst_tx_byte", 64'(tx_byte), 64'h0);
    check_bit("rst_overrun", overrun, 1'b0);
    check_bit("rst_timeout", timeout_err, 1'b0);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 check_reset_state();
    @(negedge tb_clk);
    rst = 1'b0;
  endtask

  task automatic full_cycle(input block_bytes_t b, input logic mode,
                            input int unsigned latency, input int unsigned gap,
                            output logic [63:0] got);
    logic [63:0] res;
    res = stub_des(pack_bytes(b), mode);
    send_block(b, mode, 8, gap);
    respond(res, latency);
    drain(res, gap, got);
    check_word("drained_result", got, res);
  endtask

  initial begin
    block_bytes_t blk;
    block_bytes_t ref_bytes;
    logic [63:0]  res;
    logic [63:0]  got;
    logic [63:0]  got2;
    logic [63:0]  held;

    rst           = 1'b1;
    rx_byte       = '0;
    rx_valid      = 1'b0;
    mode_in       = 1'b0;
    des_data_out  = '0;
    des_next_data = 1'b0;
    tx_ack        = 1'b0;
    repeat (2) step();
    check_reset_state();
    @(negedge tb_clk);
    rst = 1'b0;

    $display("[TB] fill, mode latch, capture and drain");
    ref_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hab, 8'hcd, 8'hef};
    send_block(ref_bytes, 1'b0, 8, 0);
    check_word("fixed_block", des_data_in, 64'h1234567890abcdef);
    respond(64'h3b3898371520f75e, 4);
    drain(64'h3b3898371520f75e, 0, got);
    check_word("fixed_result", got, 64'h3b3898371520f75e);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    check_bit("ack_in_fill_ignored", busy, 1'b0);

    $display("[TB] result on the watchdog expiry edge");
    blk = rand_bytes();
    res = stub_des(pack_bytes(blk), 1'b1);
    send_block(blk, 1'b1, 8, 1);
    respond(res, TIMEOUT - 1);
    check_bit("no_timeout_on_tie", timeout_err, 1'b0);
    drain(res, 1, got);
    check_word("tie_result", got, res);

    $display("[TB] overrun and stray next_data");
    blk = rand_bytes();
    res = stub_des(pack_bytes(blk), 1'b1);
    send_block(blk, 1'b1, 8, 0);
    held     = des_data_in;
    rx_byte  = 8'h5a;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check_bit("overrun_wait", overrun, 1'b1);
    check_bit("ready_after_overrun", des_ready, 1'b1);
    check_word("block_after_overrun", des_data_in, held);
    respond(res, 3);
    rx_valid      = 1'b1;
    des_next_data = 1'b1;
    des_data_out  = ~res;
    step();
    rx_valid      = 1'b0;
    des_next_data = 1'b0;
    check_word("tx_byte_after_overrun", 64'(tx_byte), 64'(res[63:56]));
    drain(res, 0, got);
    check_word("overrun_result", got, res);
    check_bit("overrun_sticky", overrun, 1'b1);
    full_cycle(rand_bytes(), 1'b0, 2, 0, got);

    $display("[TB] watchdog");
    blk = rand_bytes();
    send_block(blk, 1'b0, 8, 0);
    repeat (TIMEOUT - 1) step();
    check_bit("ready_before_expiry", des_ready, 1'b1);
    check_bit("timeout_before_expiry", timeout_err, 1'b0);
    step();
    check_bit("ready_after_expiry", des_ready, 1'b0);
    check_bit("timeout_set", timeout_err, 1'b1);
    check_bit("busy_after_expiry", busy, 1'b0);
    full_cycle(rand_bytes(), 1'b1, 6, 1, got);
    check_bit("timeout_sticky", timeout_err, 1'b1);

    $display("[TB] reset mid-fill and mid-drain");
    send_block(rand_bytes(), 1'b1, 3, 0);
    pulse_reset();
    full_cycle(rand_bytes(), 1'b1, 1, 0, got);
    blk = rand_bytes();
    res = stub_des(pack_bytes(blk), 1'b1);
    send_block(blk, 1'b1, 8, 0);
    respond(res, 2);
    for (int i = 0; i < 3; i++) begin
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
    end
    pulse_reset();
    full_cycle(rand_bytes(), 1'b0, 0, 0, got);

    $display("[TB] randomized blocks");
    for (int n = 0; n < 12; n++) begin
      full_cycle(rand_bytes(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, TIMEOUT - 1), 2, got);
    end

    $display("[TB] round trip");
    for (int n = 0; n < 4; n++) begin
      blk = rand_bytes();
      full_cycle(blk, 1'b0, $urandom_range(0, 8), 1, got);
      full_cycle(to_bytes(got), 1'b1, $urandom_range(0, 8), 1, got2);
      check_word("round_trip", got2, pack_bytes(blk));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_block_buffer.md
# des_block_buffer

Byte-to-block staging buffer between the I2C slave byte interface and the `des` core. It packs eight received bytes into one 64-bit block and presents it to `des` with the ready/next_data handshake. It captures the 64-bit result and returns it to the I2C transmitter one byte at a time. An optional watchdog recovers from a core that never answers.

## Interface
- `TIMEOUT`, default 0: cycles to wait for `des_next_data` before aborting; 0 disables the watchdog.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_byte` in 8: byte received from the I2C slave.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid.
- `mode_in` in 1: 0 = encrypt, 1 = decrypt; sampled with the first byte of a block.
- `des_data_in` out 64: assembled block to `des.data_in`.
- `des_ready` out 1: block valid, request to `des`.
- `des_rw_mode` out 1: latched mode to `des.rw_mode`.
- `des_data_out` in 64: result from `des`.
- `des_next_data` in 1: result valid from `des`.
- `tx_byte` out 8: result byte to the I2C transmitter.
- `tx_valid` out 1: `tx_byte` valid.
- `tx_ack` in 1: transmitter consumed `tx_byte`.
- `busy` out 1: high in every state except FILL with count 0.
- `overrun` out 1: sticky; a byte arrived while not in FILL.
- `timeout_err` out 1: sticky; the watchdog fired.

## Operation
- States are FILL, WAIT and DRAIN. Reset state is FILL with byte count 0.
- Every output resets to 0.

**FILL**
- Each `rx_valid` shifts `rx_byte` into the block, most significant byte first. The first byte lands in bits 63:56 and the eighth in bits 7:0.
- `mode_in` is latched into `des_rw_mode` on the byte taken at count 0.
- The count increments per accepted byte. On the eighth byte the count returns to 0 and the state moves to WAIT.

**WAIT**
- `des_ready` = 1. `des_data_in` and `des_rw_mode` are held stable.
- When `des_next_data` is high on a rising edge, `des_data_out` is captured into the output register. `des_ready` drops and the state moves to DRAIN.
- Watchdog (only when `TIMEOUT` > 0): `des_next_data` has not arrived by the `TIMEOUT`-th cycle in WAIT. Then `des_ready` drops, `timeout_err` is set, the block is discarded and the state returns to FILL.

**DRAIN**
- `tx_valid` = 1 and `tx_byte` = result bits 63:56.
- Each `tx_ack` shifts the next byte into place.
- On the eighth ack, `tx_valid` drops and the state returns to FILL.

**Boundary conditions**
- `rx_valid` in WAIT or DRAIN: the byte is dropped and `overrun` is set. The state is unaffected.
- `des_next_data` outside WAIT: ignored.
- `tx_ack` while `tx_valid` = 0: ignored.
- `des_next_data` and the watchdog expiry on the same edge: `des_next_data` wins and no error is raised.
- `rst` asserted at any point: returns immediately to the reset state. Any partial block and any undelivered result bytes are lost. The sticky flags are cleared.
- The sticky flags clear only on `rst`.

## Timing
- Eighth `rx_valid` at edge N: `des_ready` = 1 after edge N.
- `des_next_data` sampled at edge M: `des_ready` = 0 and `tx_valid` = 1 with the first byte after edge M.
- `tx_ack` at edge K: the next `tx_byte` is valid after edge K.
- Minimum block turnaround: 8 rx cycles + core latency + 1 + 8 tx cycles.
- All outputs are registered, with no combinational path from input to output.
- Watchdog counter width: `$clog2(TIMEOUT+1)`. It clears on entry to WAIT.

## Structure
- Shared package `des_pkg` holds:
  - `state_t` enum {FILL, WAIT, DRAIN};
  - `BLOCK_BYTES` = 8;
  - `BLOCK_W` = 64.
- One sub-module, `byte_shreg`: a 64-bit register with byte load-left shift. It is instantiated twice, once for the fill path and once for the drain path.
- The FSM, byte counter and watchdog live in `des_block_buffer`.

## Test plan
- **Fill and mode latch.** Drive bytes 12 34 56 78 90 ab cd ef with `mode_in` = 0.
  - `des_data_in` = 64'h1234567890abcdef.
  - `des_ready` rises one cycle after the last byte.
  - `des_rw_mode` = 0.
- **Capture and drain.** Stub `des` returns 64'h3b3898371520f75e with `des_next_data` 5 cycles after ready. Ack each byte immediately.
  - `tx_byte` sequence is 3b 38 98 37 15 20 f7 5e.
  - The block then returns to FILL with `busy` = 0.
- **Overrun.** Drive `rx_valid` during WAIT and during DRAIN.
  - `overrun` = 1.
  - The result bytes are unchanged.
  - The next block fills correctly from count 0.
- **Watchdog.** Set `TIMEOUT` = 16 and never assert `des_next_data`.
  - `des_ready` drops after 16 cycles in WAIT.
  - `timeout_err` = 1.
  - The next 8 bytes form a new block.
- **Reset mid-operation.** Assert `rst` after 3 bytes, then again mid-DRAIN.
  - All outputs are 0 immediately.
  - The next 8 bytes produce a full fresh block.
- **Round trip.** Encrypt then decrypt through the real `des` core, using the result bytes as input with `mode_in` = 1.
  - The drained bytes equal the original 12 34 56 78 90 ab cd ef.
